// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: writeback source encodings, load funct3
// codes and the writeback FSM state type.
package rv32i_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of an
// aligned word, extends it, and flags misaligned halfword/word accesses.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lanes[offset];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {16'd0, half_sel};
        misaligned = offset[0];
      end
      // LW and the undefined load encodings behave as a full-word access
      default: misaligned = (offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/rv32i_wb_stage.sv
// RV32I writeback stage: retires memory-stage instructions, waits for load
// data, and drives a registered register-file write port.
module rv32i_wb_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_we,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] d,
  output logic [4:0]      addr,
  output logic            we,
  output logic            load_pending,
  output logic [4:0]      pend_rd,
  output logic            misalign,
  output logic            err
);

  wb_state_t       state, state_next;
  logic [XLEN-1:0] d_next;
  logic [4:0]      addr_next;
  logic            we_next;
  logic            misalign_next;
  logic            err_next;
  logic [4:0]      pend_rd_next;
  logic [2:0]      pend_f3, pend_f3_next;
  logic [1:0]      pend_off, pend_off_next;
  logic            pend_we, pend_we_next;

  logic            accept;
  logic [31:0]     load_data;
  logic            load_misaligned;

  assign in_ready     = (state != WAIT);
  assign load_pending = (state == WAIT);
  assign accept       = in_valid && in_ready;

  rv32i_load_align u_align (
    .rdata      (mem_rdata),
    .funct3     (pend_f3),
    .offset     (pend_off),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      d        <= '0;
      addr     <= '0;
      we       <= 1'b0;
      misalign <= 1'b0;
      err      <= 1'b0;
      pend_rd  <= '0;
      pend_f3  <= '0;
      pend_off <= '0;
      pend_we  <= 1'b0;
    end else begin
      state    <= state_next;
      d        <= d_next;
      addr     <= addr_next;
      we       <= we_next;
      misalign <= misalign_next;
      err      <= err_next;
      pend_rd  <= pend_rd_next;
      pend_f3  <= pend_f3_next;
      pend_off <= pend_off_next;
      pend_we  <= pend_we_next;
    end
  end

  always_comb begin
    state_next    = state;
    d_next        = d;
    addr_next     = addr;
    we_next       = 1'b0;
    misalign_next = 1'b0;
    // a response strobe is only meaningful while a load is outstanding
    err_next      = err | (mem_rvalid && (state != WAIT));
    pend_rd_next  = pend_rd;
    pend_f3_next  = pend_f3;
    pend_off_next = pend_off;
    pend_we_next  = pend_we;

    case (state)
      IDLE, WRITE: begin
        state_next = IDLE;
        if (accept) begin
          if (in_wb_sel == WB_LOAD) begin
            pend_rd_next  = in_rd;
            pend_f3_next  = in_funct3;
            pend_off_next = in_alu_res[1:0];
            pend_we_next  = in_reg_we && (in_rd != 5'd0);
            state_next    = WAIT;
          end else if (in_reg_we && (in_rd != 5'd0)) begin
            d_next     = (in_wb_sel == WB_PC4) ? in_pc4 : in_alu_res;
            addr_next  = in_rd;
            we_next    = 1'b1;
            state_next = WRITE;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_next = IDLE;
          if (load_misaligned) begin
            misalign_next = 1'b1;
          end else if (pend_we) begin
            d_next     = load_data;
            addr_next  = pend_rd;
            we_next    = 1'b1;
            state_next = WRITE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Self-checking bench for rv32i_wb_stage: expected register writes are queued
// at stimulus time and matched by a monitor whenever we is observed high.
module tb_rv32i_wb_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_res;
  logic [31:0] in_pc4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] d;
  logic [4:0]  addr;
  logic        we;
  logic        load_pending;
  logic [4:0]  pend_rd;
  logic        misalign;
  logic        err;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] v;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  misalign_cnt = 0;

  always #5 clk = ~clk;

  rv32i_wb_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_we    (in_reg_we),
    .in_rd        (in_rd),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_alu_res   (in_alu_res),
    .in_pc4       (in_pc4),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .d            (d),
    .addr         (addr),
    .we           (we),
    .load_pending (load_pending),
    .pend_rd      (pend_rd),
    .misalign     (misalign),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (misalign === 1'b1) misalign_cnt++;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {27'd0, addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, addr}, {27'd0, e.a});
        check("wr_data", d, e.v);
        $display("write rd=%0d d=%08h (expected rd=%0d d=%08h)", addr, d, e.a, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    wr_t e;
    in_valid   = 1'b1;
    in_reg_we  = rw;
    in_rd      = rd;
    in_wb_sel  = sel;
    in_funct3  = f3;
    in_alu_res = alu;
    in_pc4     = pc4;
    if (sel != WB_LOAD && rw && rd != 5'd0) begin
      e.a = rd;
      e.v = (sel == WB_PC4) ? pc4 : alu;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_reg_we = 1'b0;
  endtask

  // Single non-load instruction, then confirm the write enable one cycle later
  task automatic alu_op(input string tag, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic exp_we);
    drive(rw, rd, sel, F3_LW, alu, pc4);
    step();
    idle_in();
    @(negedge clk);
    check({tag, "_we"}, {31'd0, we}, {31'd0, exp_we});
    step();
  endtask

  task automatic load_op(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] a, input int delay, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_d, input logic exp_mis);
    wr_t e;
    drive(1'b1, rd, WB_LOAD, f3, a, 32'd0);
    step();
    idle_in();
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_pending"}, {31'd0, load_pending}, 32'd1);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_pend_rd"}, {27'd0, pend_rd}, {27'd0, rd});
      if (i == delay - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        if (exp_we) begin
          e.a = rd;
          e.v = exp_d;
          exp_q.push_back(e);
        end
      end
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    @(negedge clk);
    check({tag, "_we"}, {31'd0, we}, {31'd0, exp_we});
    check({tag, "_misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
    check({tag, "_pending_done"}, {31'd0, load_pending}, 32'd0);
    step();
  endtask

  initial begin
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_reg_we  = 1'b0;
    in_rd      = '0;
    in_wb_sel  = '0;
    in_funct3  = '0;
    in_alu_res = '0;
    in_pc4     = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_pending", {31'd0, load_pending}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    clr = 1'b1;
    step();

    // Back-to-back ALU writes: two consecutive we cycles
    drive(1'b1, 5'd5, WB_ALU, F3_LW, 32'h0000_00AB, 32'd0);
    step();
    drive(1'b1, 5'd6, WB_ALU, F3_LW, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check("b2b_we1", {31'd0, we}, 32'd1);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    step();
    idle_in();
    @(negedge clk);
    check("b2b_we2", {31'd0, we}, 32'd1);
    step();
    @(negedge clk);
    check("b2b_idle_we", {31'd0, we}, 32'd0);
    step();

    alu_op("pc4", 1'b1, 5'd1, WB_PC4, 32'h0000_0055, 32'h0000_0104, 1'b1);
    alu_op("rsvd_sel", 1'b1, 5'd2, 2'd3, 32'hCAFE_0001, 32'h0000_0200, 1'b1);
    alu_op("rd0", 1'b1, 5'd0, WB_ALU, 32'h1111_1111, 32'd0, 1'b0);
    alu_op("no_regwe", 1'b0, 5'd4, WB_ALU, 32'h2222_2222, 32'd0, 1'b0);

    load_op("lb", 5'd3, F3_LB, 32'h0000_1003, 3, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b0);
    load_op("lhu", 5'd8, F3_LHU, 32'h0000_1002, 1, 32'h8001_FFFF, 1'b1, 32'h0000_8001, 1'b0);
    load_op("lh", 5'd9, F3_LH, 32'h0000_1002, 2, 32'h8001_FFFF, 1'b1, 32'hFFFF_8001, 1'b0);
    load_op("lw", 5'd10, F3_LW, 32'h0000_2000, 1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    load_op("lbu", 5'd11, F3_LBU, 32'h0000_2001, 2, 32'h80FF_1234, 1'b1, 32'h0000_0012, 1'b0);
    load_op("lb_rd0", 5'd0, F3_LB, 32'h0000_3000, 1, 32'h0000_0080, 1'b0, 32'd0, 1'b0);
    load_op("lw_mis", 5'd12, F3_LW, 32'h0000_1002, 1, 32'h1234_5678, 1'b0, 32'd0, 1'b1);
    step();
    check("misalign_count", misalign_cnt, 32'd1);

    // Spurious response while idle
    check("err_before", {31'd0, err}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("spur_err", {31'd0, err}, 32'd1);
    check("spur_we", {31'd0, we}, 32'd0);
    repeat (3) step();
    alu_op("post_err", 1'b1, 5'd13, WB_ALU, 32'h0000_0D0D, 32'd0, 1'b1);
    @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    step();

    // Reset while a load is outstanding
    drive(1'b1, 5'd14, WB_LOAD, F3_LW, 32'h0000_4000, 32'd0);
    step();
    idle_in();
    @(negedge clk);
    check("wait_pending", {31'd0, load_pending}, 32'd1);
    clr = 1'b0;
    step();
    @(negedge clk);
    check("clr_pending", {31'd0, load_pending}, 32'd0);
    check("clr_we", {31'd0, we}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_ready", {31'd0, in_ready}, 32'd1);
    clr = 1'b1;
    step();
    alu_op("after_clr", 1'b1, 5'd7, WB_ALU, 32'h0000_0077, 32'd0, 1'b1);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
